// File: rtl/mpy_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mpy_arbiter_if
// Purpose  : Requester and multiplier bundle for the shared-multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mpy_arbiter_if #(
  parameter int NREQ = 2
);
  logic               clear;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    sgn;
  logic [NREQ*32-1:0] a;
  logic [NREQ*32-1:0] b;
  logic [NREQ-1:0]    grant;
  logic               mpy_sync;
  logic               mpy_sgn;
  logic [31:0]        mpy_a;
  logic [31:0]        mpy_b;
  logic               prod_sync;
  logic [63:0]        prod;
  logic [NREQ-1:0]    rvalid;
  logic [63:0]        result;
  logic               busy;
  logic               err;

  // master: requesters plus multiplier; slave: the arbiter itself
  modport master (
    output clear, req, sgn, a, b, prod_sync, prod,
    input  grant, mpy_sync, mpy_sgn, mpy_a, mpy_b, rvalid, result, busy, err
  );
  modport slave (
    input  clear, req, sgn, a, b, prod_sync, prod,
    output grant, mpy_sync, mpy_sgn, mpy_a, mpy_b, rvalid, result, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/mpy_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mpy_arbiter
// Purpose  : Round-robin sharing of one fixed-latency pipelined multiplier;
//            owner tags ride alongside the product. MPYARB_CHECK_EN adds a
//            sticky spurious/missing-product error flag.
// Revision : 1.0 - initial release
// ============================================================================
module mpy_arbiter #(
  parameter int NREQ    = 2,
  parameter int MPY_LAT = 5
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mpy_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    nxt_ptr;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [PW:0]      cand;
  logic [NREQ-1:0]  grant_w;
  logic             sel_sgn;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [MPY_LAT:0] tag_vld;
  logic [PW-1:0]    tag_own [MPY_LAT+1];
  logic             ret_fire;
  logic [NREQ-1:0]  rv_next;
  logic             mpy_sync_r;
  logic             mpy_sgn_r;
  logic [31:0]      mpy_a_r;
  logic [31:0]      mpy_b_r;
  logic [NREQ-1:0]  rvalid_r;
  logic [63:0]      result_r;
  logic             busy_r;

  // Search from the pointer upward, wrapping modulo NREQ; first hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_n && !bus.clear) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = {1'b0, ptr} + (PW+1)'(i);
        if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
        if (!gnt_any && bus.req[cand[PW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_w = '0;
    if (gnt_any) grant_w[gnt_idx] = 1'b1;
  end

  assign nxt_ptr = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    sel_sgn = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_sgn = bus.sgn[k];
        sel_a   = bus.a[32*k +: 32];
        sel_b   = bus.b[32*k +: 32];
      end
    end
  end

  always_comb begin
    rv_next = '0;
    for (int k = 0; k < NREQ; k++) begin
      rv_next[k] = ret_fire && (tag_own[MPY_LAT] == PW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      mpy_sync_r <= 1'b0;
      mpy_sgn_r  <= 1'b0;
      mpy_a_r    <= '0;
      mpy_b_r    <= '0;
      tag_vld    <= '0;
      for (int i = 0; i <= MPY_LAT; i++) tag_own[i] <= '0;
      rvalid_r   <= '0;
      result_r   <= '0;
      busy_r     <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr       <= nxt_ptr;
        mpy_sgn_r <= sel_sgn;
        mpy_a_r   <= sel_a;
        mpy_b_r   <= sel_b;
      end
      mpy_sync_r <= gnt_any;
      tag_vld    <= bus.clear ? '0 : {tag_vld[MPY_LAT-1:0], gnt_any};
      tag_own[0] <= gnt_idx;
      for (int i = 1; i <= MPY_LAT; i++) tag_own[i] <= tag_own[i-1];
      rvalid_r   <= rv_next;
      if (ret_fire) result_r <= bus.prod;
      // A flush empties the pipe, so busy drops on the very next clock.
      busy_r     <= !bus.clear && (|tag_vld);
    end
  end

`ifdef MPYARB_CHECK_EN
  logic [3:0] inh_cnt;
  logic       err_r;

  assign ret_fire = tag_vld[MPY_LAT] && bus.prod_sync && !bus.clear;

  // Products issued before a flush still emerge; mute checking until they drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      if (bus.clear)            inh_cnt <= 4'(MPY_LAT + 1);
      else if (inh_cnt != '0)   inh_cnt <= inh_cnt - 4'd1;
      if ((inh_cnt == '0) && (bus.prod_sync != tag_vld[MPY_LAT])) err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  logic unused_prod_sync;

  assign ret_fire         = tag_vld[MPY_LAT] && !bus.clear;
  assign unused_prod_sync = bus.prod_sync;
  assign bus.err          = 1'b0;
`endif

  assign bus.grant    = grant_w;
  assign bus.mpy_sync = mpy_sync_r;
  assign bus.mpy_sgn  = mpy_sgn_r;
  assign bus.mpy_a    = mpy_a_r;
  assign bus.mpy_b    = mpy_b_r;
  assign bus.rvalid   = rvalid_r;
  assign bus.result   = result_r;
  assign bus.busy     = busy_r;
endmodule
`default_nettype wire

// File: tb/tb_mpy_arbiter.sv
`default_nettype none
// Bench for mpy_arbiter: directed scenarios plus random traffic against a
// queue-based model of grants, returns, busy and multiplier operands.
module tb_mpy_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic inject = 1'b0;
  always #5 clk = ~clk;

  mpy_arbiter_if #(.NREQ(NREQ)) bus ();
  mpy_arbiter #(.NREQ(NREQ), .MPY_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Behavioural multiplier: fixed latency, no stall
  logic [LAT-1:0] mv;
  logic [63:0]    mr [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mv <= '0;
    else begin
      mv    <= {mv[LAT-2:0], bus.mpy_sync};
      mr[0] <= ref_prod(bus.mpy_sgn, bus.mpy_a, bus.mpy_b);
      for (int i = 1; i < LAT; i++) mr[i] <= mr[i-1];
    end
  end
  assign bus.prod_sync = mv[LAT-1] | inject;
  assign bus.prod      = mr[LAT-1];

  typedef struct {
    int          t;
    int          due;
    int          owner;
    logic [63:0] val;
  } op_t;

  op_t         pend[$];
  int          n, m_ptr, total, bad;
  logic        m_sync, m_sgn, m_err;
  logic [31:0] m_a, m_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] erv;
    logic [63:0]     er;
    logic            busy_e;
    bit              have;
    erv = '0; er = '0; busy_e = 1'b0; have = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due == n) begin
        erv[pend[i].owner] = 1'b1;
        er   = pend[i].val;
        have = 1'b1;
      end
      if (pend[i].t <= n - 2 && pend[i].due >= n) busy_e = 1'b1;
    end
    chk("rvalid", 64'(bus.rvalid), 64'(erv));
    if (have) chk("result", bus.result, er);
    chk("busy", 64'(bus.busy), 64'(busy_e));
    chk("mpy_sync", 64'(bus.mpy_sync), 64'(m_sync));
    chk("mpy_sgn", 64'(bus.mpy_sgn), 64'(m_sgn));
    chk("mpy_a", 64'(bus.mpy_a), 64'(m_a));
    chk("mpy_b", 64'(bus.mpy_b), 64'(m_b));
    chk("err", 64'(bus.err), 64'(m_err));
    while (pend.size() > 0 && pend[0].due <= n) void'(pend.pop_front());
  endtask

  // One clock: predict and check the grant, advance, check registered outputs.
  task automatic step(output int g);
    int              k;
    logic [NREQ-1:0] eg;
    #1;
    g = -1;
    if (!bus.clear) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (g < 0 && bus.req[k]) g = k;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", 64'(bus.grant), 64'(eg));
    if (g >= 0) begin
      k     = g;
      m_sgn = bus.sgn[k];
      m_a   = bus.a[32*k +: 32];
      m_b   = bus.b[32*k +: 32];
      pend.push_back('{n, n + LAT + 2, k, ref_prod(m_sgn, m_a, m_b)});
      m_ptr = (k + 1) % NREQ;
    end
    m_sync = (g >= 0);
`ifdef MPYARB_CHECK_EN
    if (inject) m_err = 1'b1;
`endif
    if (bus.clear) pend.delete();
    @(posedge clk);
    #1;
    n++;
    check_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sync", 64'(bus.mpy_sync), 64'd0);
    chk("rst_a", 64'(bus.mpy_a), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    pend.delete();
    m_ptr = 0; m_sync = 1'b0; m_sgn = 1'b0; m_a = '0; m_b = '0; m_err = 1'b0;
    @(posedge clk);
    #1;
    n++;
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int k, input logic s, input logic [31:0] x, input logic [31:0] y);
    bus.sgn[k]        = s;
    bus.a[32*k +: 32] = x;
    bus.b[32*k +: 32] = y;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.clear = 1'b0; bus.req = '0; bus.sgn = '0; bus.a = '0; bus.b = '0;
    total = 0; bad = 0; n = 0;
    m_ptr = 0; m_sync = 1'b0; m_sgn = 1'b0; m_a = '0; m_b = '0; m_err = 1'b0;
    #2;
    apply_reset();

    // Signed -2 * 3 from requester 0, result seven clocks after grant
    set_op(0, 1'b1, 32'hFFFF_FFFE, 32'd3);
    bus.req = 2'b01;
    step(g);
    bus.req = 2'b00;
    repeat (6) step(g);
    chk("t1_rvalid", 64'(bus.rvalid), 64'd1);
    chk("t1_r", bus.result, 64'hFFFF_FFFF_FFFF_FFFA);
    step(g);
    chk("t1_busy_off", 64'(bus.busy), 64'd0);

    // Back-to-back unsigned and signed extremes, different owners
    set_op(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req = 2'b10;
    step(g);
    set_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    bus.req = 2'b01;
    step(g);
    bus.req = 2'b00;
    repeat (5) step(g);
    chk("t3_rvalid1", 64'(bus.rvalid), 64'd2);
    chk("t3_r1", bus.result, 64'hFFFF_FFFE_0000_0001);
    step(g);
    chk("t3_rvalid0", 64'(bus.rvalid), 64'd1);
    chk("t3_r0", bus.result, 64'h4000_0000_0000_0000);
    repeat (3) step(g);

    // Flush with three operations in flight, then a normal operation
    bus.req = 2'b01;
    repeat (3) begin
      set_op(0, 1'($urandom), $urandom, $urandom);
      step(g);
    end
    bus.req = 2'b00;
    step(g);
    bus.clear = 1'b1;
    bus.req   = 2'b01;
    step(g);
    bus.clear = 1'b0;
    chk("t4_busy_off", 64'(bus.busy), 64'd0);
    step(g);
    bus.req = 2'b00;
    repeat (8) step(g);

    // Reset mid-stream, then alternating service from pointer 0
    bus.req = 2'b11;
    repeat (3) begin
      set_op(0, 1'($urandom), pick(), pick());
      set_op(1, 1'($urandom), pick(), pick());
      step(g);
    end
    apply_reset();
    #1;
    chk("t5_first_grant", 64'(bus.grant), 64'd1);
    repeat (12) begin
      step(g);
      set_op(g, 1'($urandom), pick(), pick());
    end
    bus.req = 2'b00;
    repeat (9) step(g);

    // Random traffic with withdrawals and occasional flushes
    g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (k == g || !bus.req[k]) begin
          bus.req[k] = ($urandom_range(0, 3) != 0);
          set_op(k, 1'($urandom), pick(), pick());
        end else if ($urandom_range(0, 9) == 0) begin
          bus.req[k] = 1'b0;
        end
      end
      bus.clear = ($urandom_range(0, 29) == 0);
      step(g);
    end
    bus.clear = 1'b0;
    bus.req   = 2'b00;
    repeat (10) step(g);

`ifdef MPYARB_CHECK_EN
    // Spurious product with an empty pipe: sticky error, nothing forwarded
    inject = 1'b1;
    step(g);
    inject = 1'b0;
    chk("t6_err_set", 64'(bus.err), 64'd1);
    chk("t6_no_rvalid", 64'(bus.rvalid), 64'd0);
    bus.clear = 1'b1;
    step(g);
    bus.clear = 1'b0;
    step(g);
    chk("t6_err_after_clear", 64'(bus.err), 64'd1);
    apply_reset();
    step(g);
    chk("t6_err_after_reset", 64'(bus.err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
